// File: rtl/wb_regfile.sv
// Write-back stage and 32x32 architectural register file with two bypassed
// combinational read ports, a registered WB dest/value for forwarding and a retired counter.
module wb_regfile #(
   parameter logic [3:0] OP_LW = 4'b1000,
   parameter logic [3:0] OP_SW = 4'b1001,
   parameter logic [3:0] OP_BR = 4'b1010
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        hold,
   input  logic [73:0] MAResult,
   input  logic [4:0]  rs_addr,
   input  logic [4:0]  rt_addr,
   output logic [31:0] rs_data,
   output logic [31:0] rt_data,
   output logic [4:0]  WBDest,
   output logic [31:0] WBValue,
   output logic [31:0] retired
);

   logic        maValid;
   logic [3:0]  maOpcode;
   logic [4:0]  maDest;
   logic [31:0] aluAnswer;
   logic [31:0] memAnswer;

   logic        accept;
   logic        writeEn;
   logic [31:0] writeData;

   logic [31:0] regFile [32];

   assign maValid   = MAResult[73];
   assign maOpcode  = MAResult[72:69];
   assign maDest    = MAResult[68:64];
   assign aluAnswer = MAResult[63:32];
   assign memAnswer = MAResult[31:0];

   assign accept    = !reset && !hold;
   assign writeData = (maOpcode == OP_LW) ? memAnswer : aluAnswer;
   assign writeEn   = accept && maValid && (maDest != 5'd0) &&
                      (maOpcode != OP_SW) && (maOpcode != OP_BR);

   // NOTE: every register is cleared on reset, so this array maps to flops rather than a RAM macro.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) regFile[i] <= '0;
      end else if (writeEn) begin
         // NOTE: non-blocking so decode reads in the same cycle see the old array (bypass covers it).
         regFile[maDest] <= writeData;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         WBDest  <= '0;
         WBValue <= '0;
         retired <= '0;
      end else if (accept) begin
         WBDest  <= writeEn ? maDest : 5'd0;
         WBValue <= writeEn ? writeData : 32'd0;
         if (maValid) retired <= retired + 32'd1;
      end
   end

   // Register 0 reads zero regardless of array contents or an in-flight write.
   always_comb begin
      rs_data = '0;
      if (rs_addr != 5'd0) rs_data = (writeEn && maDest == rs_addr) ? writeData : regFile[rs_addr];
   end

   always_comb begin
      rt_data = '0;
      if (rt_addr != 5'd0) rt_data = (writeEn && maDest == rt_addr) ? writeData : regFile[rt_addr];
   end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reset, bypass, load/store/branch, r0, hold and counter wrap.
module tb_wb_regfile;

   logic        clk = 1'b0;
   logic        reset;
   logic        hold;
   logic [73:0] MAResult;
   logic [4:0]  rs_addr;
   logic [4:0]  rt_addr;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic [4:0]  WBDest;
   logic [31:0] WBValue;
   logic [31:0] retired;

   int total = 0;
   int bad   = 0;
   logic [31:0] expRetired;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_LW  = 4'b1000;
   localparam logic [3:0] OP_SW  = 4'b1001;
   localparam logic [3:0] OP_BR  = 4'b1010;
   localparam logic [3:0] OP_UNK = 4'b1111;

   always #5 clk = ~clk;

   wb_regfile dut (
      .clk(clk), .reset(reset), .hold(hold), .MAResult(MAResult),
      .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
      .WBDest(WBDest), .WBValue(WBValue), .retired(retired)
   );

   function automatic logic [73:0] bundle(input logic v, input logic [3:0] op, input logic [4:0] d,
                                          input logic [31:0] alu, input logic [31:0] mem);
      return {v, op, d, alu, mem};
   endfunction

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; hold = 1'b0; MAResult = '0; rs_addr = '0; rt_addr = '0;
      tick(); tick();
      @(negedge clk);
      reset = 1'b0;
      expRetired = 0;

      // Reset state: every register reads zero on both ports
      for (int i = 0; i < 32; i++) begin
         rs_addr = 5'(i); rt_addr = 5'(31 - i);
         #1;
         check($sformatf("reset_rs%0d", i), rs_data, 32'd0);
         check($sformatf("reset_rt%0d", 31 - i), rt_data, 32'd0);
      end
      check("reset_wbdest", 32'(WBDest), 32'd0);
      check("reset_wbvalue", WBValue, 32'd0);
      check("reset_retired", retired, 32'd0);

      // ALU write with same-cycle bypass on both ports
      MAResult = bundle(1'b1, OP_ADD, 5'd5, 32'h1234, 32'h0);
      rs_addr = 5'd5; rt_addr = 5'd5;
      #1;
      check("byp_rs5", rs_data, 32'h1234);
      check("byp_rt5", rt_data, 32'h1234);
      tick(); expRetired++;
      MAResult = '0;
      #1;
      check("arr_rs5", rs_data, 32'h1234);
      check("wb_dest5", 32'(WBDest), 32'd5);
      check("wb_value5", WBValue, 32'h1234);
      check("retired1", retired, expRetired);

      // Load selects memory answer
      MAResult = bundle(1'b1, OP_LW, 5'd7, 32'h40, 32'hDEADBEEF);
      rs_addr = 5'd7; rt_addr = 5'd5;
      #1;
      check("lw_byp", rs_data, 32'hDEADBEEF);
      check("lw_other_port", rt_data, 32'h1234);
      tick(); expRetired++;
      // Store to same dest: no write, no bypass
      MAResult = bundle(1'b1, OP_SW, 5'd7, 32'h55, 32'h0);
      #1;
      check("sw_no_byp", rs_data, 32'hDEADBEEF);
      check("lw_wbdest", 32'(WBDest), 32'd7);
      tick(); expRetired++;
      check("sw_wbdest", 32'(WBDest), 32'd0);
      check("sw_wbvalue", WBValue, 32'd0);
      check("sw_reg7", rs_data, 32'hDEADBEEF);
      check("sw_retired", retired, expRetired);

      // Branch: no write, still counts
      MAResult = bundle(1'b1, OP_BR, 5'd8, 32'h77, 32'h0);
      rs_addr = 5'd8;
      tick(); expRetired++;
      check("br_reg8", rs_data, 32'd0);
      check("br_retired", retired, expRetired);

      // r0 write attempt: reads zero same and next cycle, still counts
      MAResult = bundle(1'b1, OP_ADD, 5'd0, 32'hFFFF, 32'h0);
      rs_addr = 5'd0; rt_addr = 5'd0;
      #1;
      check("r0_same_rs", rs_data, 32'd0);
      check("r0_same_rt", rt_data, 32'd0);
      tick(); expRetired++;
      check("r0_next", rs_data, 32'd0);
      check("r0_wbdest", 32'(WBDest), 32'd0);
      check("r0_retired", retired, expRetired);

      // Unknown opcode writes the ALU answer
      MAResult = bundle(1'b1, OP_UNK, 5'd10, 32'hA5A5, 32'h1111);
      rs_addr = 5'd10;
      tick(); expRetired++;
      check("unk_reg10", rs_data, 32'hA5A5);
      check("unk_wbvalue", WBValue, 32'hA5A5);

      // Hold for 3 cycles: nothing commits, outputs hold
      hold = 1'b1;
      MAResult = bundle(1'b1, OP_ADD, 5'd9, 32'h3, 32'h0);
      rs_addr = 5'd9;
      #1;
      check("hold_no_byp", rs_data, 32'd0);
      for (int c = 0; c < 3; c++) begin
         tick();
         check($sformatf("hold%0d_reg9", c), rs_data, 32'd0);
         check($sformatf("hold%0d_retired", c), retired, expRetired);
         check($sformatf("hold%0d_wbdest", c), 32'(WBDest), 32'd10);
         check($sformatf("hold%0d_wbvalue", c), WBValue, 32'hA5A5);
      end
      @(negedge clk);
      hold = 1'b0;
      #1;
      check("unhold_byp", rs_data, 32'h3);
      tick(); expRetired++;
      MAResult = '0;
      #1;
      check("unhold_reg9", rs_data, 32'h3);
      check("unhold_wbdest", 32'(WBDest), 32'd9);
      check("unhold_retired", retired, expRetired);
      tick();
      check("idle_retired", retired, expRetired);
      check("idle_wbdest", 32'(WBDest), 32'd0);

      // Reset beats hold and a pending write; array cleared
      @(negedge clk);
      reset = 1'b1; hold = 1'b1;
      MAResult = bundle(1'b1, OP_ADD, 5'd4, 32'h44, 32'h0);
      rs_addr = 5'd4; rt_addr = 5'd5;
      tick();
      reset = 1'b0; hold = 1'b0; MAResult = '0;
      #1;
      check("rst_reg4", rs_data, 32'd0);
      check("rst_reg5", rt_data, 32'd0);
      check("rst_retired", retired, 32'd0);
      check("rst_wbdest", 32'(WBDest), 32'd0);

      // Counter wrap from 0xFFFFFFFF
      @(negedge clk);
      force dut.retired = 32'hFFFFFFFF;
      MAResult = bundle(1'b1, OP_ADD, 5'd1, 32'h1, 32'h0);
      #3;
      release dut.retired;
      tick();
      MAResult = '0;
      check("wrap_retired", retired, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed=running expected=finished");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "timeout");
   end

endmodule
